// File: rtl/lemonpc_pkg.sv
// Shared LemonPC core constants: architectural register width, register
// index width and the hardwired-zero register index.
package lemonpc_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register.
// Issue sets a bit, writeback clears it, and issue beats writeback in the same
// cycle because the newly issued producer is younger than the one retiring.
module regfile_scoreboard
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int NUM_WR     = 1,
  localparam int DEPTH     = 1 << ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  output logic [DEPTH-1:0]             busy,
  output logic [DEPTH-1:0]             clr
);

  logic [DEPTH-1:0] set;

  // Decode issue and writeback ports into one-hot set/clear vectors.
  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise the unassigned paths infer latches.
    set = '0;
    clr = '0;
    if (iss_en) begin
      set[iss_addr] = 1'b1;
    end
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w]) begin
        clr[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
      end
    end
    // The zero register can never have a pending producer.
    set[REG_ZERO] = 1'b0;
    clr[REG_ZERO] = 1'b0;
  end

  // Busy vector update: set dominates clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      busy <= '0;
    end else begin
      busy <= set | (busy & ~clr);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file for the LemonPC core.
// NUM_RD combinational read ports, NUM_WR synchronous write ports, register 0
// hardwired to zero, optional same-cycle write-to-read bypass, and a per-register
// pending-write scoreboard reported on each read port.
module regfile_mp
  import lemonpc_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         iss_en,
  input  logic [ADDR_WIDTH-1:0]        iss_addr
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Register 0 has no storage; it is a constant zero on every read.
  logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      clr;

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_WR     (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .clr      (clr)
  );

  // Register storage: ports visited lowest first so the highest port wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage array is reset on purpose: architectural registers
      // must read zero after reset, so it is built from resettable flops.
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != ADDR_WIDTH'(REG_ZERO))) begin
          // NOTE: when several non-blocking writes target the same element in
          // one edge, the last one executed takes effect.
          regs[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;

    assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

    // Read mux: zero register, else stored value overridden by the highest
    // same-cycle write hit when bypass is enabled.
    always_comb begin
      data = '0;
      if (addr != ADDR_WIDTH'(REG_ZERO)) begin
        data = regs[addr];
        if (BYPASS) begin
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
              data = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end

    assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = data;
    // A retiring write this cycle hides the busy bit when its data is bypassed.
    assign rd_busy[p] = busy[addr] && !(BYPASS && clr[addr]);
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (bypass on / off) share one stimulus
// stream; an array-plus-busy-flags model predicts every read port each cycle,
// and directed cycles pin the model with hand-computed literals.
module tb_regfile_mp;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int DEPTH = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NRD*AW-1:0] rd_addr;
  logic [NWR-1:0]    wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*DW-1:0] wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [NRD*DW-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]    rd_busy_b, rd_busy_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit run_cmp  = 1'b0;

  logic [DW-1:0] m_regs [DEPTH];
  bit            m_busy [DEPTH];

  always #5 clk = ~clk;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
  );

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NRD), .NUM_WR(NWR), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  function automatic logic [DW-1:0] exp_data(input int p, input bit byp);
    logic [AW-1:0] a = rd_addr[p*AW +: AW];
    if (a == '0) return '0;
    if (byp) begin
      for (int w = NWR - 1; w >= 0; w--) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == a) return wr_data[w*DW +: DW];
      end
    end
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input int p, input bit byp);
    logic [AW-1:0] a = rd_addr[p*AW +: AW];
    if (a == '0) return 1'b0;
    if (byp) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] == a) return 1'b0;
      end
    end
    return m_busy[a];
  endfunction

  initial model_clear();
  always @(negedge rst_n) model_clear();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0) m_regs[wr_addr[w*AW +: AW]] = wr_data[w*DW +: DW];
      end
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w]) m_busy[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (iss_en && iss_addr != '0) m_busy[iss_addr] = 1'b1;
    end
  end

  // Compare both instances against the model every cycle while out of reset.
  always @(negedge clk) begin
    #2;
    if (run_cmp && rst_n === 1'b1) begin
      for (int p = 0; p < NRD; p++) begin
        check("cmp_data_byp",   rd_data_b[p*DW +: DW], exp_data(p, 1'b1));
        check("cmp_busy_byp",   32'(rd_busy_b[p]),     32'(exp_busy(p, 1'b1)));
        check("cmp_data_nobyp", rd_data_n[p*DW +: DW], exp_data(p, 1'b0));
        check("cmp_busy_nobyp", 32'(rd_busy_n[p]),     32'(exp_busy(p, 1'b0)));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic next();
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input int w, input int a, input logic [DW-1:0] d);
    wr_en[w]             = 1'b1;
    wr_addr[w*AW +: AW]  = AW'(a);
    wr_data[w*DW +: DW]  = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic iss(input int a);
    iss_en   = 1'b1;
    iss_addr = AW'(a);
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    rd(0, 5);
    rd(1, 9);
    #1;
    check("reset_data_b", rd_data_b[31:0], 32'h0);
    check("reset_data_n", rd_data_n[63:32], 32'h0);
    check("reset_busy_b", 32'(rd_busy_b), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    run_cmp = 1'b1;

    // Basic write then read; x0 ignores writes.
    next(); wr(0, 5, 32'hDEADBEEF);
    next(); rd(0, 5); rd(1, 0); #1;
    check("basic_rd5_b", rd_data_b[31:0], 32'hDEADBEEF);
    check("basic_rd0_b", rd_data_b[63:32], 32'h0);
    check("basic_rd5_n", rd_data_n[31:0], 32'hDEADBEEF);
    next(); wr(0, 0, 32'h1234); rd(0, 0); #1;
    check("x0_bypass_b", rd_data_b[31:0], 32'h0);
    next(); rd(0, 0); #1;
    check("x0_after_b", rd_data_b[31:0], 32'h0);
    check("x0_after_n", rd_data_n[31:0], 32'h0);

    // Bypass versus stored value.
    next(); wr(0, 7, 32'hA5A5A5A5); rd(0, 7); #1;
    check("byp_same_b", rd_data_b[31:0], 32'hA5A5A5A5);
    check("byp_same_n", rd_data_n[31:0], 32'h0);
    next(); rd(0, 7); #1;
    check("byp_next_n", rd_data_n[31:0], 32'hA5A5A5A5);

    // Two ports writing one register: highest port wins.
    next(); wr(0, 3, 32'h1); wr(1, 3, 32'h2); rd(0, 3); #1;
    check("conf_same_b", rd_data_b[31:0], 32'h2);
    check("conf_same_n", rd_data_n[31:0], 32'h0);
    next(); rd(0, 3); rd(1, 3); #1;
    check("conf_next_n0", rd_data_n[31:0], 32'h2);
    check("conf_next_b1", rd_data_b[63:32], 32'h2);

    // Scoreboard.
    next(); iss(9); rd(0, 9); #1;
    check("iss_same_b", 32'(rd_busy_b[0]), 32'h0);
    next(); rd(0, 9); #1;
    check("iss_next_b", 32'(rd_busy_b[0]), 32'h1);
    check("iss_next_n", 32'(rd_busy_n[0]), 32'h1);
    next(); wr(0, 9, 32'h99); rd(0, 9); #1;
    check("clr_same_b", 32'(rd_busy_b[0]), 32'h0);
    check("clr_same_n", 32'(rd_busy_n[0]), 32'h1);
    check("clr_data_b", rd_data_b[31:0], 32'h99);
    next(); rd(0, 9); #1;
    check("clr_next_n", 32'(rd_busy_n[0]), 32'h0);
    next(); iss(9); wr(1, 9, 32'h77); rd(0, 9); #1;
    check("setclr_same_b", 32'(rd_busy_b[0]), 32'h0);
    next(); rd(0, 9); #1;
    check("setclr_next_b", 32'(rd_busy_b[0]), 32'h1);
    check("setclr_next_n", 32'(rd_busy_n[0]), 32'h1);
    check("setclr_data_n", rd_data_n[31:0], 32'h77);
    next(); iss(0); rd(0, 0); rd(1, 9); #1;
    check("iss0_busy9_b", 32'(rd_busy_b[1]), 32'h1);
    next(); rd(0, 0); #1;
    check("iss0_next_b", 32'(rd_busy_b[0]), 32'h0);

    // Asynchronous reset mid-cycle, observed before the next edge.
    next(); rd(0, 5); rd(1, 9); #1;
    check("pre_rst_data", rd_data_b[31:0], 32'hDEADBEEF);
    check("pre_rst_busy", 32'(rd_busy_b[1]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_data_b", rd_data_b[31:0], 32'h0);
    check("async_rst_data_n", rd_data_n[31:0], 32'h0);
    check("async_rst_busy_b", 32'(rd_busy_b[1]), 32'h0);
    check("async_rst_busy_n", 32'(rd_busy_n[1]), 32'h0);
    next(); rst_n = 1'b1;
    next(); rd(0, 5); rd(1, 7); #1;
    check("post_rst_x5", rd_data_n[31:0], 32'h0);
    check("post_rst_x7", rd_data_b[63:32], 32'h0);

    // Random traffic on a narrow index window, with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      next();
      if (rst_n == 1'b0) rst_n = 1'b1;
      for (int p = 0; p < NRD; p++) rd(p, $urandom_range(0, 7));
      for (int w = 0; w < NWR; w++) begin
        if ($urandom_range(0, 1) == 1) wr(w, $urandom_range(0, 7), $urandom);
      end
      if ($urandom_range(0, 2) == 0) iss($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        idle();
        #1 rst_n = 1'b0;
      end
    end

    next();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
